// File: rtl/rot_pkg.sv
// Shared definitions for the rotated-vector serializer.
//   N_DEF, WIDTH_DEF : default vector length (words) and word width (bits)
//   log2c()          : ceiling log2, used to size the word index
//   state_t          : serializer FSM states
package rot_pkg;

  localparam int N_DEF     = 32;
  localparam int WIDTH_DEF = 8;

  // Ceiling log2 with a floor of 1 so a one-word vector still gets a
  // legal one-bit index.
  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/rot_serializer.sv
// Captures an N-word vector from an upstream barrel rotator and emits it one
// word per accepted cycle, word 0 first, with valid/ready on both sides.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset; aborts any vector in flight
//   in_vec     : N x WIDTH rotated vector
//   in_valid   : in_vec is valid
//   in_ready   : vector can be captured this cycle
//   out_data   : current word, buffer[out_idx]
//   out_valid  : out_data is valid
//   out_ready  : downstream accepts out_data this cycle
//   out_idx    : index of the word on out_data
//   out_last   : out_data carries word N-1
//   busy       : a vector is being serialized
module rot_serializer
  import rot_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDX_W = log2c(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_vec [N],
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] buffer [N];
  logic [IDX_W-1:0] idx;
  logic             at_last;
  logic             in_xfer;
  logic             out_xfer;

  assign at_last  = (idx == LAST_IDX);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic. A capture coinciding with the final word keeps the
  // FSM in SEND so the next vector follows with no bubble.
  // NOTE: the default assignment up front keeps this block latch-free.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_xfer) state_nxt = SEND;
      SEND: if (out_xfer && at_last && !in_xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. out_data is a plain mux from the buffer so the first word
  // appears the cycle after capture. in_ready depends on rst only through
  // the IDLE arm, which forces it low while reset is held.
  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    in_ready  = 1'b0;
    out_data  = '0;
    unique case (state)
      IDLE: in_ready = rst;
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = buffer[idx];
        in_ready  = out_ready && at_last;
      end
      default: ;
    endcase
  end

  assign out_idx  = idx;
  assign out_last = out_valid && at_last;

  // Word index: cleared on capture, advanced on each accepted word, wrapped
  // explicitly at N-1 so non-power-of-two N stays in range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (in_xfer) begin
      idx <= '0;
    end else if (out_xfer) begin
      idx <= at_last ? '0 : idx + IDX_W'(1);
    end
  end

  // NOTE: the vector buffer has no reset; its contents are never observed
  // before a capture, so reset wiring on N*WIDTH flops buys nothing.
  always_ff @(posedge clk) begin
    if (in_xfer) buffer <= in_vec;
  end

endmodule

// File: tb/tb_rot_serializer.sv
// Directed bench for rot_serializer: reset values, idle hold, streaming,
// backpressure, back-to-back vectors, input stability and reset abort.
module tb_rot_serializer;

  localparam int N     = 32;
  localparam int WIDTH = 8;
  localparam int IDX_W = 5;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_vec [N];
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  rot_serializer #(.N(N), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Hand-defined vector patterns.
  function automatic logic [7:0] vec_word(input int kind, input int i);
    case (kind)
      0:       return 8'((i + 11) % 32);
      1:       return 8'(i);
      2:       return 8'(255 - i);
      3:       return 8'(3 * i + 1);
      4:       return 8'hAA;
      default: return 8'(i) ^ 8'h5A;
    endcase
  endfunction

  task automatic set_vec(input int kind);
    for (int i = 0; i < N; i++) in_vec[i] = vec_word(kind, i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int exp_k;
    int cyc;
    bit tog;

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_vec(1);

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_idx",   32'(out_idx),   0);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_busy",      32'(busy),      0);
    check("rst_in_ready",  32'(in_ready),  0);
    rst = 1'b1;

    // Idle hold.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_out_valid", 32'(out_valid), 0);
      check("idle_in_ready",  32'(in_ready),  1);
      check("idle_out_idx",   32'(out_idx),   0);
    end

    // Basic streaming with out_ready held high.
    set_vec(0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("basic_data", 32'(out_data), 32'(vec_word(0, k)));
      check("basic_last", 32'(out_last), (k == N - 1) ? 1 : 0);
      check("basic_busy", 32'(busy), 1);
      if (k == 0) check("basic_first_idx", 32'(out_idx), 0);
    end
    @(negedge clk);
    check("basic_busy_after", 32'(busy), 0);
    check("basic_valid_after", 32'(out_valid), 0);

    // Backpressure: out_ready toggles 1,0,1,0...
    set_vec(0);
    in_valid = 1'b1;
    exp_k = 0;
    cyc   = 0;
    tog   = 1'b1;
    while (exp_k < N && cyc < 200) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      if (out_valid) begin
        check("bp_data", 32'(out_data), 32'(vec_word(0, exp_k)));
        check("bp_idx",  32'(out_idx),  32'(exp_k));
        out_ready = tog;
        if (tog) exp_k++;
        tog = !tog;
      end
    end
    check("bp_word_count", 32'(exp_k), 32'(N));
    @(negedge clk);
    check("bp_valid_after", 32'(out_valid), 0);
    out_ready = 1'b1;

    // Back-to-back: vector B queued while A streams.
    set_vec(1);
    in_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      if (k == 0) set_vec(2);
      check("b2b_a_data",     32'(out_data), 32'(k));
      check("b2b_a_in_ready", 32'(in_ready), (k == N - 1) ? 1 : 0);
    end
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      if (k == 0) in_valid = 1'b0;
      check("b2b_b_valid",    32'(out_valid), 1);
      check("b2b_b_data",     32'(out_data),  32'(255 - k));
      check("b2b_b_in_ready", 32'(in_ready),  (k == N - 1) ? 1 : 0);
    end
    @(negedge clk);
    check("b2b_valid_after", 32'(out_valid), 0);

    // Input stability: in_vec overwritten mid-vector.
    set_vec(3);
    in_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("stab_data", 32'(out_data), 32'(vec_word(3, k)));
      if (k == 5) set_vec(4);
    end
    @(negedge clk);

    // Reset abort during word 17, then restart.
    set_vec(0);
    in_valid = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("abort_data", 32'(out_data), 32'(vec_word(0, k)));
    end
    #2 rst = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_busy",      32'(busy),      0);
    check("abort_out_idx",   32'(out_idx),   0);
    check("abort_out_data",  32'(out_data),  0);
    check("abort_in_ready",  32'(in_ready),  0);
    @(negedge clk);
    rst = 1'b1;
    set_vec(5);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("restart_valid", 32'(out_valid), 1);
    check("restart_idx",   32'(out_idx),   0);
    check("restart_data0", 32'(out_data),  32'(vec_word(5, 0)));
    @(negedge clk);
    check("restart_idx1",  32'(out_idx),   1);
    check("restart_data1", 32'(out_data),  32'(vec_word(5, 1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rot_serializer.md
ROT_SERIALIZER -- requirements
Module: rot_serializer

Interface
REQ-001 Parameter N, default 32: number of words per rotated vector.
REQ-002 Parameter WIDTH, default 8: bits per word.
REQ-003 Parameter IDX_W, default log2(N) = 5: width of the word index.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset, asynchronous and active-low.
REQ-006 in_vec  input  N x WIDTH (unpacked array): rotated vector from the upstream barrel rotator.
REQ-007 in_valid  input  1: in_vec is valid.
REQ-008 in_ready  output  1: block can capture in_vec this cycle.
REQ-009 out_data  output  WIDTH: current serialized word.
REQ-010 out_valid  output  1: out_data is valid.
REQ-011 out_ready  input  1: downstream accepts out_data this cycle.
REQ-012 out_idx  output  IDX_W: index of the word on out_data.
REQ-013 out_last  output  1: high when out_idx == N-1 and out_valid is high.
REQ-014 busy  output  1: high in state SEND.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and SEND.
REQ-016 An input transfer SHALL occur on a rising edge where in_valid && in_ready are both high; on that edge in_vec is copied into the internal N-word buffer.
REQ-017 in_ready SHALL be high in IDLE, and in SEND only while the final word is being accepted (out_valid && out_ready && out_idx == N-1); it is low otherwise.
REQ-018 IDLE -> SEND on an input transfer; out_idx is set to 0 and out_valid rises on the same edge. Capture-to-first-word latency is therefore 1 cycle.
REQ-019 An output transfer SHALL occur on an edge where out_valid && out_ready are both high; out_idx then increments by 1.
REQ-020 out_data SHALL equal buffer[out_idx], with word 0 emitted first.
REQ-021 While out_valid is high and out_ready is low, out_data, out_idx and out_last SHALL hold stable.
REQ-022 On an output transfer with out_idx == N-1 and no simultaneous input transfer: SEND -> IDLE, out_valid falls, out_idx wraps to 0.
REQ-023 On an output transfer with out_idx == N-1 and a simultaneous input transfer: the buffer reloads, the state stays SEND, out_idx = 0 and out_valid stays high, giving zero bubble cycles between vectors.
REQ-024 in_vec changes while in SEND (other than in the REQ-023 cycle) SHALL NOT affect the buffer.
REQ-025 out_idx arithmetic SHALL be unsigned modulo N; for N not a power of two, the counter wraps explicitly at N-1.

Reset
REQ-026 While rst is low: state = IDLE, out_valid = 0, out_idx = 0, out_data = 0, busy = 0, in_ready = 0; the buffer contents are don't-care.
REQ-027 Reset asserted mid-vector SHALL abort the vector immediately, without waiting for a clock edge; the remaining words are discarded.
REQ-028 The first input transfer SHALL be possible on the first rising edge after rst is released.

Structure
REQ-029 A shared package rot_pkg SHALL hold the N/WIDTH defaults, the log2 function used for IDX_W, and the state enum {IDLE, SEND}.
REQ-030 No sub-module is required; the buffer, counter and FSM are implemented in a single module.
REQ-031 out_data SHALL be driven by a mux from the buffer, with no extra pipeline register, so the latency of REQ-018 holds.

Verification
REQ-032 Basic: in_vec[i] = (i+11) mod 32, out_ready held 1 -> out_data sequence 11,12,...,31,0,...,10 on 32 consecutive cycles; out_last high only on word 10; busy is low on the cycle after word 10.
REQ-033 Backpressure: same vector, out_ready toggling 1,0,1,0 -> each word is held stable while out_ready = 0; the 32 words arrive in order with no drops or duplicates.
REQ-034 Back-to-back: vector A (in_vec[i] = i), then vector B (in_vec[i] = 255-i) presented with in_valid = 1 -> in_ready pulses only on A's last word; B word 255 follows A word 31 with no gap.
REQ-035 Input stability: in_vec changed to all 0xAA at word 5 of a vector -> words 6..31 still match the captured values.
REQ-036 Reset abort: rst driven low during word 17 -> out_valid drops asynchronously; after release, a new vector starts at word 0 with 1-cycle latency.
REQ-037 Idle hold: in_valid = 0 for 20 cycles after reset -> out_valid stays 0, in_ready stays 1, out_idx stays 0.
